// File: rtl/ema_level_detector.sv
// Hysteresis level detector for the EMA filter output.
// It uses two thresholds and only changes level after HOLD_N consecutive qualifying samples.
// Defining EMA_DET_PEAK_TRACK_EN adds a peak_out port that tracks the highest sample of each high episode.
module ema_level_detector #(
  parameter int DATA_W = 8,
  parameter int TH_HI  = 128,
  parameter int TH_LO  = 64,
  parameter int HOLD_N = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ema_in,
  input  logic              in_valid,
  output logic              level_high,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic [7:0]        qual_cnt,
`ifdef EMA_DET_PEAK_TRACK_EN
  output logic [CNT_W-1:0]  event_count,
  output logic [DATA_W-1:0] peak_out
`else
  output logic [CNT_W-1:0]  event_count
`endif
);

  typedef enum logic [1:0] {LOW, ARM_HI, HIGH, ARM_LO} state_t;

  localparam logic [DATA_W-1:0] TH_HI_V = DATA_W'(TH_HI);
  localparam logic [DATA_W-1:0] TH_LO_V = DATA_W'(TH_LO);
  localparam logic [7:0]        HOLD_V  = 8'(HOLD_N);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_next;
  logic [7:0] qual_next, qual_inc;
  logic       rise_next, fall_next;
  logic       ge_hi, le_lo;

  assign ge_hi    = (ema_in >= TH_HI_V);
  assign le_lo    = (ema_in <= TH_LO_V);
  assign qual_inc = qual_cnt + 8'd1;

  // Samples that land between the two thresholds never qualify, so they
  // always drop an armed state back to its stable state.
  always_comb begin
    state_next = state;
    qual_next  = qual_cnt;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (in_valid) begin
      case (state)
        LOW: begin
          if (ge_hi) begin
            if (HOLD_V == 8'd1) begin
              state_next = HIGH;
              qual_next  = 8'd0;
              rise_next  = 1'b1;
            end else begin
              state_next = ARM_HI;
              qual_next  = 8'd1;
            end
          end else begin
            qual_next = 8'd0;
          end
        end
        ARM_HI: begin
          if (ge_hi) begin
            if (qual_inc == HOLD_V) begin
              state_next = HIGH;
              qual_next  = 8'd0;
              rise_next  = 1'b1;
            end else begin
              qual_next = qual_inc;
            end
          end else begin
            state_next = LOW;
            qual_next  = 8'd0;
          end
        end
        HIGH: begin
          if (le_lo) begin
            if (HOLD_V == 8'd1) begin
              state_next = LOW;
              qual_next  = 8'd0;
              fall_next  = 1'b1;
            end else begin
              state_next = ARM_LO;
              qual_next  = 8'd1;
            end
          end else begin
            qual_next = 8'd0;
          end
        end
        ARM_LO: begin
          if (le_lo) begin
            if (qual_inc == HOLD_V) begin
              state_next = LOW;
              qual_next  = 8'd0;
              fall_next  = 1'b1;
            end else begin
              qual_next = qual_inc;
            end
          end else begin
            state_next = HIGH;
            qual_next  = 8'd0;
          end
        end
        default: begin
          state_next = LOW;
          qual_next  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOW;
      qual_cnt    <= 8'd0;
      level_high  <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      event_count <= '0;
    end else begin
      state      <= state_next;
      qual_cnt   <= qual_next;
      level_high <= (state_next == HIGH) || (state_next == ARM_LO);
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      if (rise_next && (event_count != CNT_MAX)) begin
        event_count <= event_count + CNT_W'(1);
      end
    end
  end

`ifdef EMA_DET_PEAK_TRACK_EN
  // The peak is loaded at the rise and then follows the maximum of the
  // high episode. It is left alone after the fall until the next rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_out <= '0;
    end else if (rise_next) begin
      peak_out <= ema_in;
    end else if (in_valid && ((state == HIGH) || (state == ARM_LO)) && (ema_in > peak_out)) begin
      peak_out <= ema_in;
    end
  end
`endif

endmodule

// File: tb/tb_ema_level_detector.sv
// Scoreboard bench for ema_level_detector. The counter is narrowed to 2 bits so that saturation can be reached.
// Stimulus pushes hand-computed expectations into a queue, and a monitor process pops them one cycle later and compares.
module tb_ema_level_detector;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [7:0]       ema_in;
  logic             in_valid;
  logic             level_high;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [7:0]       qual_cnt;
  logic [CNT_W-1:0] event_count;
`ifdef EMA_DET_PEAK_TRACK_EN
  logic [7:0]       peak_out;
`endif

  typedef struct {
    int   step;
    logic lvl;
    logic rise;
    logic fall;
    int   q;
    int   e;
    logic chk_peak;
    int   peak;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  ema_level_detector #(
    .DATA_W(8), .TH_HI(128), .TH_LO(64), .HOLD_N(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ema_in(ema_in),
    .in_valid(in_valid),
    .level_high(level_high),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .qual_cnt(qual_cnt),
`ifdef EMA_DET_PEAK_TRACK_EN
    .event_count(event_count),
    .peak_out(peak_out)
`else
    .event_count(event_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int stp, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d expected %0d", name, stp, act, exp);
    end
  endtask

  task automatic pushExp(input logic lvl, input logic r, input logic f, input int q, input int e,
                         input logic cp, input int pk);
    exp_t x;
    x.step = step; x.lvl = lvl; x.rise = r; x.fall = f; x.q = q; x.e = e;
    x.chk_peak = cp; x.peak = pk;
    sb.push_back(x);
    step++;
  endtask

  task automatic applyReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; ema_in = 8'd0;
      pushExp(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic lvl, input logic r,
                               input logic f, input int q, input int e);
    @(negedge clk);
    reset = 1'b0; in_valid = v; ema_in = d;
    pushExp(lvl, r, f, q, e, 0, 0);
  endtask

  task automatic applyStimulusPeak(input logic v, input logic [7:0] d, input logic lvl, input logic r,
                                   input logic f, input int q, input int e, input int pk);
    @(negedge clk);
    reset = 1'b0; in_valid = v; ema_in = d;
    pushExp(lvl, r, f, q, e, 1, pk);
  endtask

  // Monitor: the outputs are registered, so every driven cycle yields one response just after the next rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput("level_high", x.step, int'(level_high), int'(x.lvl));
        checkOutput("rise_pulse", x.step, int'(rise_pulse), int'(x.rise));
        checkOutput("fall_pulse", x.step, int'(fall_pulse), int'(x.fall));
        checkOutput("qual_cnt", x.step, int'(qual_cnt), x.q);
        checkOutput("event_count", x.step, int'(event_count), x.e);
`ifdef EMA_DET_PEAK_TRACK_EN
        if (x.chk_peak) checkOutput("peak_out", x.step, int'(peak_out), x.peak);
`endif
      end
    end
  end

  initial begin
    int pe, ne;
    reset = 1'b1; in_valid = 1'b0; ema_in = 8'd0;

    // Reset, then idle zero samples
    applyReset(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Rising ramp: 128 arms the detector and the fourth qualifying sample causes the rise
    applyStimulus(1, 50,  0, 0, 0, 0, 0);
    applyStimulus(1, 90,  0, 0, 0, 0, 0);
    applyStimulus(1, 120, 0, 0, 0, 0, 0);
    applyStimulus(1, 128, 0, 0, 0, 1, 0);
    applyStimulus(1, 160, 0, 0, 0, 2, 0);
    applyStimulus(1, 190, 0, 0, 0, 3, 0);
    applyStimulus(1, 200, 1, 1, 0, 0, 1);
    applyStimulus(1, 200, 1, 0, 0, 0, 1);

    // Decay: 64 arms the fall detection and the fourth qualifying sample causes the fall
    applyStimulus(1, 150, 1, 0, 0, 0, 1);
    applyStimulus(1, 100, 1, 0, 0, 0, 1);
    applyStimulus(1, 64,  1, 0, 0, 1, 1);
    applyStimulus(1, 40,  1, 0, 0, 2, 1);
    applyStimulus(1, 30,  1, 0, 0, 3, 1);
    applyStimulus(1, 20,  0, 0, 1, 0, 1);
    applyStimulus(1, 20,  0, 0, 0, 0, 1);

    // Alternating samples in the band never reach a count of 2
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) applyStimulus(1, 130, 0, 0, 0, 1, 1);
      else            applyStimulus(1, 100, 0, 0, 0, 0, 1);
    end

    // Reset in the middle of qualification
    for (int i = 1; i <= 3; i++) applyStimulus(1, 130, 0, 0, 0, i, 1);
    applyReset(1);
    applyStimulus(1, 0,   0, 0, 0, 0, 0);
    applyStimulus(1, 130, 0, 0, 0, 1, 0);
    applyStimulus(1, 100, 0, 0, 0, 0, 0);

    // Gaps in in_valid hold the count; data on invalid cycles is ignored
    applyStimulus(1, 130, 0, 0, 0, 1, 0);
    applyStimulus(0, 130, 0, 0, 0, 1, 0);
    applyStimulus(1, 130, 0, 0, 0, 2, 0);
    applyStimulus(0, 0,   0, 0, 0, 2, 0);
    applyStimulus(1, 130, 0, 0, 0, 3, 0);
    applyStimulus(0, 0,   0, 0, 0, 3, 0);
    applyStimulus(1, 130, 1, 1, 0, 0, 1);
    applyStimulus(0, 0,   1, 0, 0, 0, 1);
    applyStimulus(1, 50,  1, 0, 0, 1, 1);
    applyStimulus(0, 50,  1, 0, 0, 1, 1);
    applyStimulus(1, 100, 1, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) applyStimulus(1, 60, 1, 0, 0, i, 1);
    applyStimulus(1, 60, 0, 0, 1, 0, 1);

    // Saturation: event_count reads 1, then 2, 3, 3, 3
    for (int k = 0; k < 4; k++) begin
      pe = (k + 1 > 3) ? 3 : k + 1;
      ne = (k + 2 > 3) ? 3 : k + 2;
      for (int i = 1; i <= 3; i++) applyStimulus(1, 128, 0, 0, 0, i, pe);
      applyStimulus(1, 128, 1, 1, 0, 0, ne);
      for (int i = 1; i <= 3; i++) applyStimulus(1, 64, 1, 0, 0, i, ne);
      applyStimulus(1, 64, 0, 0, 1, 0, ne);
    end

    // Peak tracking across a high episode, and the held value after the fall
    for (int i = 1; i <= 3; i++) applyStimulus(1, 130, 0, 0, 0, i, 3);
    applyStimulusPeak(1, 130, 1, 1, 0, 0, 3, 130);
    applyStimulusPeak(1, 150, 1, 0, 0, 0, 3, 150);
    applyStimulusPeak(1, 140, 1, 0, 0, 0, 3, 150);
    applyStimulusPeak(1, 200, 1, 0, 0, 0, 3, 200);
    applyStimulusPeak(1, 180, 1, 0, 0, 0, 3, 200);
    for (int i = 1; i <= 3; i++) applyStimulusPeak(1, 10, 1, 0, 0, i, 3, 200);
    applyStimulusPeak(1, 10,  0, 0, 1, 0, 3, 200);
    applyStimulusPeak(1, 100, 0, 0, 0, 0, 3, 200);

    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
